// File: rtl/paddle_event_ctrl_pkg.sv
// Shared constants, state encodings and position payload for paddle_event_ctrl.
// Speed ramping is built only when SPEED_RAMP_EN is defined at compile time.
package paddle_event_ctrl_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned XCOORD_W    = COORD_W + 1;
  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned LIVES_W     = 2;

  localparam int unsigned BAR_Y       = 440;
  localparam int unsigned BAR_W       = 64;
  localparam int unsigned INIT_SPEED  = 1;
  localparam int unsigned MAX_SPEED   = 9;
  localparam int unsigned LEVEL_STEP  = 5;
  localparam int unsigned LIVES       = 3;
  localparam int unsigned HOLD_FRAMES = 60;

  localparam int unsigned HOLD_W      = $clog2(HOLD_FRAMES);
  localparam int unsigned CATCH_W     = $clog2(LEVEL_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] bar_x;
  } pos_t;

  // Right edge of the bar, widened by one bit so bars near the screen edge never wrap.
  function automatic logic [XCOORD_W-1:0] bar_right(input logic [COORD_W-1:0] bar_x);
    return {1'b0, bar_x} + XCOORD_W'(BAR_W - 1);
  endfunction

endpackage

// File: rtl/paddle_event_ctrl_if.sv
// Frame-rate game bus between the video/input side and the rule controller.
interface paddle_event_ctrl_if;
  import paddle_event_ctrl_pkg::*;

  logic               frame_tick;
  logic               start;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [COORD_W-1:0] bar_x;
  logic               get;
  logic               lose;
  logic [SPEED_W-1:0] bar_move_speed;
  logic [LIVES_W-1:0] lives;
  logic               ball_reset;
  logic               game_over;

  modport master (
    output frame_tick, start, ball_x, ball_y, bar_x,
    input  get, lose, bar_move_speed, lives, ball_reset, game_over
  );

  modport slave (
    input  frame_tick, start, ball_x, ball_y, bar_x,
    output get, lose, bar_move_speed, lives, ball_reset, game_over
  );

endinterface

// File: rtl/paddle_event_ctrl_cross_detect.sv
// Per-frame bar-line crossing detector: tracks previous ball row and decides catch/miss.
// hit_c/miss_c are the same-cycle decisions; hit/miss are their one-cycle registered pulses.
module paddle_event_ctrl_cross_detect
  import paddle_event_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic en,
  input  logic force_zero,
  input  pos_t pos,
  output logic hit_c,
  output logic miss_c,
  output logic hit,
  output logic miss
);

  logic [COORD_W-1:0] prev_y;
  logic               cross_c;
  logic               in_bar_c;
  logic               eval_c;

  assign eval_c   = frame_tick & en;
  assign cross_c  = (prev_y < COORD_W'(BAR_Y)) && (pos.ball_y >= COORD_W'(BAR_Y));
  assign in_bar_c = (pos.ball_x >= pos.bar_x) &&
                    ({1'b0, pos.ball_x} <= bar_right(pos.bar_x));
  assign hit_c    = eval_c & cross_c & in_bar_c;
  assign miss_c   = eval_c & cross_c & ~in_bar_c;

  // Clearing prev_y on serve takes priority over any coincident frame sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_y <= '0;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      hit  <= hit_c;
      miss <= miss_c;
      if (force_zero) begin
        prev_y <= '0;
      end else if (eval_c) begin
        prev_y <= pos.ball_y;
      end
    end
  end

endmodule

// File: rtl/paddle_event_ctrl.sv
// Game-rule controller: catch/miss pulses, lives, hold-after-miss and game state.
// Define SPEED_RAMP_EN to ramp bar_move_speed every LEVEL_STEP catches; otherwise it is fixed.
module paddle_event_ctrl
  import paddle_event_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  paddle_event_ctrl_if.slave sif
);

  state_e             state;
  state_e             state_nxt;
  logic [LIVES_W-1:0] lives_q;
  logic [LIVES_W-1:0] lives_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;
  logic               start_q;
  logic               ball_reset_q;
  logic               ball_reset_nxt;
  logic               game_over_q;
  logic               game_over_nxt;
  logic               start_rise_c;
  logic               play_c;
  logic               force_zero_c;
  logic               hit_c;
  logic               miss_c;
  logic               hit_q;
  logic               miss_q;
  pos_t               pos;

  assign pos.ball_x   = sif.ball_x;
  assign pos.ball_y   = sif.ball_y;
  assign pos.bar_x    = sif.bar_x;
  assign start_rise_c = sif.start & ~start_q;
  assign play_c       = (state == PLAY);

  paddle_event_ctrl_cross_detect u_cross_detect (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (sif.frame_tick),
    .en         (play_c),
    .force_zero (force_zero_c),
    .pos        (pos),
    .hit_c      (hit_c),
    .miss_c     (miss_c),
    .hit        (hit_q),
    .miss       (miss_q)
  );

  // State register plus registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lives_q      <= '0;
      hold_cnt     <= '0;
      start_q      <= 1'b1;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      lives_q      <= lives_nxt;
      hold_cnt     <= hold_cnt_nxt;
      start_q      <= sif.start;
      ball_reset_q <= ball_reset_nxt;
      game_over_q  <= game_over_nxt;
    end
  end

  // Next-state logic; lives and state move on the same edge that registers lose.
  always_comb begin
    state_nxt    = state;
    lives_nxt    = lives_q;
    hold_cnt_nxt = hold_cnt;
    force_zero_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise_c) begin
          state_nxt    = PLAY;
          lives_nxt    = LIVES_W'(LIVES);
          force_zero_c = 1'b1;
        end
      end
      PLAY: begin
        if (miss_c) begin
          lives_nxt = lives_q - LIVES_W'(1);
          if (lives_q == LIVES_W'(1)) begin
            state_nxt = OVER;
          end else begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
          end
        end
      end
      HOLD: begin
        if (sif.frame_tick) begin
          if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_nxt    = PLAY;
            force_zero_c = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      OVER: begin
        if (start_rise_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ball_reset_nxt = (state_nxt != PLAY);
    game_over_nxt  = (state_nxt == OVER);
  end

`ifdef SPEED_RAMP_EN
  logic [SPEED_W-1:0] speed_q;
  logic [CATCH_W-1:0] catch_cnt;
  logic               new_game_c;

  assign new_game_c = (state == IDLE) & start_rise_c;

  // Driven by the registered catch pulse so speed moves one cycle after get.
  always_ff @(posedge clk) begin
    if (rst || new_game_c) begin
      speed_q   <= SPEED_W'(INIT_SPEED);
      catch_cnt <= '0;
    end else if (hit_q) begin
      if (catch_cnt == CATCH_W'(LEVEL_STEP - 1)) begin
        catch_cnt <= '0;
        if (speed_q < SPEED_W'(MAX_SPEED)) begin
          speed_q <= speed_q + SPEED_W'(1);
        end
      end else begin
        catch_cnt <= catch_cnt + CATCH_W'(1);
      end
    end
  end

  assign sif.bar_move_speed = speed_q;
`else
  assign sif.bar_move_speed = SPEED_W'(INIT_SPEED);
`endif

  assign sif.get        = hit_q;
  assign sif.lose       = miss_q;
  assign sif.lives      = lives_q;
  assign sif.ball_reset = ball_reset_q;
  assign sif.game_over  = game_over_q;

endmodule

// File: tb/tb_paddle_event_ctrl.sv
// Scoreboard bench for paddle_event_ctrl: directed frames push expected get/lose events,
// a monitor pops and checks them when a pulse appears.
module tb_paddle_event_ctrl;
  import paddle_event_ctrl_pkg::*;

  localparam int EV_NONE = 0;
  localparam int EV_GET  = 1;
  localparam int EV_LOSE = 2;

  typedef struct {
    bit is_get;
    int speed;
    int speed_after;
    int lives;
    bit ball_reset;
    bit game_over;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  paddle_event_ctrl_if bus ();

  paddle_event_ctrl dut (
    .clk (clk),
    .rst (rst),
    .sif (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   m_lives = 0;
  int   m_speed = 1;
  int   m_catches = 0;
  bit   post_pend = 1'b0;
  int   post_speed = 0;

  int hit_bx  [8] = '{130, 100, 163, 0, 63, 1023, 1023, 500};
  int hit_brx [8] = '{100, 100, 100, 0,  0,  990,  960, 480};

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every get/lose pulse must match the head of the expected queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (post_pend) begin
      post_pend = 1'b0;
      chk("speed_after_get", 32'(bus.bar_move_speed), post_speed);
    end
    if (bus.get || bus.lose) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({bus.get, bus.lose}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_latency",   cyc, e.due);
        chk("get",             32'(bus.get), 32'(e.is_get));
        chk("lose",            32'(bus.lose), 32'(!e.is_get));
        chk("speed_at_pulse",  32'(bus.bar_move_speed), e.speed);
        chk("lives_at_pulse",  32'(bus.lives), e.lives);
        chk("ball_reset_at_pulse", 32'(bus.ball_reset), 32'(e.ball_reset));
        chk("game_over_at_pulse",  32'(bus.game_over), 32'(e.game_over));
        if (e.is_get) begin
          post_pend  = 1'b1;
          post_speed = e.speed_after;
        end
      end
    end
  end

  // One frame: tick high for one cycle, with the expected decision queued.
  task automatic tick(input int by, input int bx, input int brx, input int ev);
    exp_t e;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.ball_y     = 10'(by);
    bus.ball_x     = 10'(bx);
    bus.bar_x      = 10'(brx);
    e.due = cyc + 1;
    if (ev == EV_GET) begin
      e.is_get = 1'b1;
      e.speed  = m_speed;
      m_catches++;
`ifdef SPEED_RAMP_EN
      if (m_catches == 5) begin
        m_catches = 0;
        if (m_speed < 9) m_speed++;
      end
`endif
      e.speed_after = m_speed;
      e.lives       = m_lives;
      e.ball_reset  = 1'b0;
      e.game_over   = 1'b0;
      exp_q.push_back(e);
    end else if (ev == EV_LOSE) begin
      m_lives--;
      e.is_get      = 1'b0;
      e.speed       = m_speed;
      e.speed_after = m_speed;
      e.lives       = m_lives;
      e.ball_reset  = 1'b1;
      e.game_over   = (m_lives == 0);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic catch_at(input int bx, input int brx, input bit edge_rows);
    tick(edge_rows ? 439 : 430, bx, brx, EV_NONE);
    tick(edge_rows ? 440 : 445, bx, brx, EV_GET);
  endtask

  task automatic miss_at(input int bx, input int brx);
    tick(430, bx, brx, EV_NONE);
    tick(445, bx, brx, EV_LOSE);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    m_lives   = 3;
    m_speed   = 1;
    m_catches = 0;
    chk("start_lives",      32'(bus.lives), 3);
    chk("start_speed",      32'(bus.bar_move_speed), 1);
    chk("start_ball_reset", 32'(bus.ball_reset), 0);
    chk("start_game_over",  32'(bus.game_over), 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Ball parked for exactly HOLD_FRAMES ticks; the coincident tick and first play frame are silent.
  task automatic hold_phase();
    for (int i = 1; i <= 60; i++) begin
      if (i == 60) tick(445, 0, 500, EV_NONE);
      else         tick(300, 0, 500, EV_NONE);
      chk("hold_ball_reset", 32'(bus.ball_reset), (i < 60) ? 1 : 0);
    end
    tick(20, 0, 500, EV_NONE);
    chk("first_frame_ball_reset", 32'(bus.ball_reset), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_get"},        32'(bus.get), 0);
    chk({tag, "_lose"},       32'(bus.lose), 0);
    chk({tag, "_speed"},      32'(bus.bar_move_speed), 1);
    chk({tag, "_lives"},      32'(bus.lives), 0);
    chk({tag, "_ball_reset"}, 32'(bus.ball_reset), 1);
    chk({tag, "_game_over"},  32'(bus.game_over), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.ball_x     = '0;
    bus.ball_y     = '0;
    bus.bar_x      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Game 1: catches, boundaries and speed ramp/saturation.
    start_pulse();
    catch_at(130, 100, 1'b0);
    for (int i = 0; i < 49; i++) begin
      catch_at(hit_bx[i % 8], hit_brx[i % 8], (i % 3) == 0);
      if (i == 4) tick(500, 130, 100, EV_NONE);
    end

    // Reset mid-play, coincident with a frame that would otherwise be a catch.
    tick(430, 130, 100, EV_NONE);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.ball_y     = 10'd445;
    rst            = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk_reset_values("midplay_reset");
    rst       = 1'b0;
    m_lives   = 0;
    m_speed   = 1;
    m_catches = 0;

    // Game 2: misses, hold periods and game over.
    start_pulse();
    catch_at(130, 100, 1'b0);
    miss_at(99, 100);
    hold_phase();
    miss_at(164, 100);
    hold_phase();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("play_ignores_start", 32'(bus.ball_reset), 0);
    chk("lives_before_last",  32'(bus.lives), 1);
    miss_at(0, 1);
    repeat (3) @(negedge clk);
    chk("over_held_start", 32'(bus.game_over), 1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("over_stays",       32'(bus.game_over), 1);
    chk("over_lives",       32'(bus.lives), 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_game_over",  32'(bus.game_over), 0);
    chk("idle_ball_reset", 32'(bus.ball_reset), 1);
    @(negedge clk);
    bus.start = 1'b0;

    // Game 3 starts from IDLE with fresh lives.
    start_pulse();
    catch_at(163, 100, 1'b1);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
